// File: rtl/zone_read_ctrl.sv
// zone_read_ctrl
//   Read-side sequencer for the zone-mean FIFO. Once per frame it pulls
//   ROW_LEN*ROWS bytes from the FIFO and re-times them into a valid/ready
//   stream tagged with zone coordinates. It covers the FIFO read latency and
//   the stale empty flag, and a small skid buffer absorbs downstream stalls.
//
// Ports
//   clk          single clock (FIFO read side)
//   rst          synchronous, active-high reset
//   frame_start  one-cycle pulse, arms one frame
//   fifo_empty   FIFO empty flag (lags rd_en by one cycle)
//   fifo_dout    FIFO read data, valid RD_LAT cycles after rd_start
//   rd_start     read request to the FIFO wrapper
//   zone_data    zone mean at the stream head
//   zone_x       column index of the stream head
//   zone_y       row index of the stream head
//   zone_valid   stream valid
//   zone_ready   stream ready
//   busy         high whenever not IDLE
//   frame_done   one-cycle pulse, frame complete
//   overrun_err  sticky, frame_start seen while busy
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for frame_start
// READ  | issuing FIFO reads until the whole frame has been requested
// DRAIN | all reads issued, waiting for in-flight data and skid to empty
// DONE  | single cycle, frame_done asserted

module zone_read_ctrl #(
  parameter int ROW_LEN    = 40,
  parameter int ROWS       = 24,
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 4   // power of two, >= RD_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       rd_start,
  output logic [7:0] zone_data,
  output logic [5:0] zone_x,
  output logic [4:0] zone_y,
  output logic       zone_valid,
  input  logic       zone_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun_err
);

  localparam int PW  = $clog2(SKID_DEPTH);
  localparam int CW  = PW + 1;
  localparam int IFW = $clog2(RD_LAT + 1);
  localparam int SW  = CW + 1;

  localparam logic [10:0]   TOTAL_W = 11'(ROW_LEN * ROWS);
  localparam logic [SW-1:0] DEPTH_W = SW'(SKID_DEPTH);
  localparam logic [5:0]    X_LAST  = 6'(ROW_LEN - 1);
  localparam logic [4:0]    Y_LAST  = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [10:0]       issued;
  logic              rd_start_q;
  logic [RD_LAT-1:0] lat_sr, lat_nxt;
  logic [IFW-1:0]    inflight;
  logic [7:0]        skid_mem [SKID_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     skid_count;
  logic [SW-1:0]     credit_used;
  logic [5:0]        x_q;
  logic [4:0]        y_q;
  logic              push, pop, accept;

  // Each rd_start walks down lat_sr; the bit falling off the end marks the
  // cycle in which fifo_dout carries that read's data.
  always_comb begin
    lat_nxt    = lat_sr;
    lat_nxt[0] = rd_start;
    for (int i = 1; i < RD_LAT; i++) lat_nxt[i] = lat_sr[i-1];
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + IFW'(lat_sr[i]);
  end

  // Credit counts every read not yet handed downstream; a pop in the same
  // cycle gives no credit, so the skid buffer can never overflow.
  assign credit_used = SW'(skid_count) + SW'(inflight);

  // The empty flag is stale for one cycle after a read, hence never two
  // reads back to back.
  assign rd_start = (state == READ) && !rst && !fifo_empty && !rd_start_q &&
                    (credit_used < DEPTH_W) && (issued < TOTAL_W);

  assign push   = lat_sr[RD_LAT-1];
  assign pop    = zone_valid && zone_ready;
  assign accept = (state == IDLE) && frame_start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = READ;
      READ:    if (issued == TOTAL_W) state_nxt = DRAIN;
      DRAIN:   if ((inflight == '0) && (skid_count == '0)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issued      <= '0;
      rd_start_q  <= 1'b0;
      lat_sr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      skid_count  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      overrun_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_start_q <= rd_start;
      lat_sr     <= lat_nxt;

      if (accept)        issued <= '0;
      else if (rd_start) issued <= issued + 11'd1;

      // Pointers wrap naturally because SKID_DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   skid_count <= skid_count + 1'b1;
        2'b01:   skid_count <= skid_count - 1'b1;
        default: skid_count <= skid_count;
      endcase

      // Coordinates belong to the stream head and advance on each transfer;
      // the wrap after the last zone leaves them at (0,0) for the next frame.
      if (accept) begin
        x_q <= '0;
        y_q <= '0;
      end else if (pop) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? 5'd0 : y_q + 5'd1;
        end else begin
          x_q <= x_q + 6'd1;
        end
      end

      if (frame_start && (state != IDLE)) overrun_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) skid_mem[wr_ptr] <= fifo_dout;
  end

  assign zone_valid = (skid_count != '0);
  assign zone_data  = zone_valid ? skid_mem[rd_ptr] : 8'd0;
  assign zone_x     = x_q;
  assign zone_y     = y_q;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule
